// File: rtl/udp_rx_ctrl_if.sv
// Byte-stream, IP-checker handshake and payload/status bundle for udp_rx_ctrl.
interface udp_rx_ctrl_if #(parameter int CNT_W = 16);
  logic [7:0]       data_in;
  logic             data_valid;
  logic [15:0]      udp_port;
  logic             ip_rx_en;
  logic             ip_header_done;
  logic [7:0]       m_tdata;
  logic             m_tvalid;
  logic             m_tlast;
  logic             frame_err;
  logic [CNT_W-1:0] frames_ok;
  logic [CNT_W-1:0] frames_drop;

  modport slave (
    input  data_in, data_valid, udp_port, ip_header_done,
    output ip_rx_en, m_tdata, m_tvalid, m_tlast, frame_err, frames_ok, frames_drop
  );

  modport master (
    output data_in, data_valid, udp_port, ip_header_done,
    input  ip_rx_en, m_tdata, m_tvalid, m_tlast, frame_err, frames_ok, frames_drop
  );
endinterface

// File: rtl/udp_rx_ctrl.sv
// Receive sequencer: Ethernet/IP/UDP header walk, port/length filter, payload streaming.
//   state    | meaning
//   IDLE     | between frames, waiting for byte 0
//   ETH_HDR  | MAC addresses and EtherType (bytes 1-13)
//   IP_HDR   | IP header, checker enabled at byte 14, verdict at byte 34
//   UDP_HDR  | UDP header, port/length verdict at byte 41
//   PAYLOAD  | streaming rem payload bytes
//   WAIT_END | payload done, ignore padding until data_valid drops
//   DROP     | frame rejected, ignore until data_valid drops
module udp_rx_ctrl #(
  parameter int          CNT_W       = 16,
  parameter logic [15:0] ETH_TYPE_IP = 16'h0800
) (
  input logic          aclk,
  input logic          areset,
  udp_rx_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, WAIT_END, DROP
  } state_t;

  state_t           state_q, state_d;
  logic [10:0]      byte_cnt_q, byte_cnt_d;
  logic [7:0]       eth_hi_q, eth_hi_d;
  logic [15:0]      port_q, port_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      rem_q, rem_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             ferr_q, ferr_d;
  logic [CNT_W-1:0] ok_q, ok_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             ok_inc, drop_inc;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      eth_hi_q   <= '0;
      port_q     <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ok_q       <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      eth_hi_q   <= eth_hi_d;
      port_q     <= port_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      ferr_q     <= ferr_d;
      ok_q       <= ok_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    eth_hi_d   = eth_hi_q;
    port_d     = port_q;
    len_d      = len_q;
    rem_d      = rem_q;
    tdata_d    = tdata_q;
    tvalid_d   = 1'b0;
    tlast_d    = 1'b0;
    ferr_d     = 1'b0;
    ok_inc     = 1'b0;
    drop_inc   = 1'b0;
    ok_d       = ok_q;
    drop_d     = drop_q;

    if (!bus.data_valid) begin
      byte_cnt_d = '0;
      state_d    = IDLE;
      // Only a frame cut short inside its payload is reported; header truncation is silent.
      if (state_q == PAYLOAD) begin
        ferr_d   = 1'b1;
        drop_inc = 1'b1;
      end
    end else begin
      if (byte_cnt_q != 11'h7FF) byte_cnt_d = byte_cnt_q + 11'd1;
      unique case (state_q)
        IDLE:    state_d = ETH_HDR;
        ETH_HDR: begin
          if (byte_cnt_q == 11'd12) eth_hi_d = bus.data_in;
          if (byte_cnt_q == 11'd13)
            state_d = ({eth_hi_q, bus.data_in} == ETH_TYPE_IP) ? IP_HDR : DROP;
        end
        IP_HDR: begin
          if (byte_cnt_q == 11'd34) state_d = bus.ip_header_done ? UDP_HDR : DROP;
        end
        UDP_HDR: begin
          if (byte_cnt_q == 11'd36 || byte_cnt_q == 11'd37) port_d = {port_q[7:0], bus.data_in};
          if (byte_cnt_q == 11'd38 || byte_cnt_q == 11'd39) len_d  = {len_q[7:0], bus.data_in};
          if (byte_cnt_q == 11'd41) begin
            if (port_q != bus.udp_port)  state_d = DROP;
            else if (len_q < 16'd8)      state_d = DROP;
            else if (len_q == 16'd8) begin
              ok_inc  = 1'b1;
              state_d = WAIT_END;
            end else begin
              rem_d   = len_q - 16'd8;
              state_d = PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          tdata_d  = bus.data_in;
          tvalid_d = 1'b1;
          rem_d    = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            tlast_d = 1'b1;
            ok_inc  = 1'b1;
            state_d = WAIT_END;
          end
        end
        WAIT_END, DROP: ;
        default: state_d = IDLE;
      endcase
    end

    if (state_d == DROP && state_q != DROP) drop_inc = 1'b1;
    if (ok_inc && ok_q != '1)     ok_d   = ok_q + 1'b1;
    if (drop_inc && drop_q != '1) drop_d = drop_q + 1'b1;
  end

  assign bus.ip_rx_en    = (state_q == IP_HDR) && (byte_cnt_q == 11'd14) && bus.data_valid;
  assign bus.m_tdata     = tdata_q;
  assign bus.m_tvalid    = tvalid_q;
  assign bus.m_tlast     = tlast_q;
  assign bus.frame_err   = ferr_q;
  assign bus.frames_ok   = ok_q;
  assign bus.frames_drop = drop_q;

endmodule

// File: tb/tb_udp_rx_ctrl.sv
// Directed bench for udp_rx_ctrl: builds frames byte by byte and checks outputs and counters.
module tb_udp_rx_ctrl;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  udp_rx_ctrl_if #(.CNT_W(16)) bus ();
  udp_rx_ctrl #(.CNT_W(16), .ETH_TYPE_IP(16'h0800)) dut (
    .aclk(aclk), .areset(areset), .bus(bus.slave)
  );

  always #5 aclk = ~aclk;

  // Monitor: cumulative event counts, sampled on the falling edge.
  int   cur_idx = 0;
  int   tv_cnt = 0, tl_cnt = 0, fe_cnt = 0, ip_cnt = 0;
  int   ip_idx = -1, tv_start = -1, tv_last = -1, tl_idx = -1;
  logic prev_tv = 1'b0;
  logic [7:0] last_tdata = 8'h00;

  always @(negedge aclk) begin
    if (bus.ip_rx_en) begin ip_cnt++; ip_idx = cur_idx; end
    if (bus.m_tvalid) begin
      tv_cnt++;
      if (!prev_tv) tv_start = cur_idx - 1;
      tv_last    = cur_idx - 1;
      last_tdata = bus.m_tdata;
    end
    if (bus.m_tlast) begin tl_cnt++; tl_idx = cur_idx - 1; end
    if (bus.frame_err) fe_cnt++;
    prev_tv = bus.m_tvalid;
  end

  int b_tv, b_tl, b_fe, b_ip;
  logic [7:0] frm [0:127];

  task automatic snap();
    b_tv = tv_cnt; b_tl = tl_cnt; b_fe = fe_cnt; b_ip = ip_cnt;
  endtask

  task automatic build(input logic [15:0] etype, input logic [15:0] port,
                       input logic [15:0] len, input int n);
    for (int i = 0; i < n; i++) frm[i] = (i >= 42) ? (8'hA0 ^ i[7:0]) : (8'h10 + i[7:0]);
    frm[12] = etype[15:8]; frm[13] = etype[7:0];
    frm[36] = port[15:8];  frm[37] = port[7:0];
    frm[38] = len[15:8];   frm[39] = len[7:0];
  endtask

  task automatic drive(input int n, input bit hdr_ok, input bit close);
    for (int k = 0; k < n; k++) begin
      @(posedge aclk); #1;
      bus.data_valid     = 1'b1;
      bus.data_in        = frm[k];
      bus.ip_header_done = hdr_ok && (k == 34);
      cur_idx            = k;
    end
    if (close) begin
      @(posedge aclk); #1;
      bus.data_valid     = 1'b0;
      bus.ip_header_done = 1'b0;
      bus.data_in        = 8'h00;
      cur_idx            = n;
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge aclk);
  endtask

  task automatic do_reset();
    bus.data_valid = 1'b0; bus.data_in = 8'h00; bus.ip_header_done = 1'b0;
    bus.udp_port = 16'h1234;
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    cur_idx = 0;
    settle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %0b exp 0", bus.m_tvalid); end
    checks++; if (bus.m_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %0b exp 0", bus.m_tlast); end
    checks++; if (bus.m_tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata got %0h exp 0", bus.m_tdata); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr got %0b exp 0", bus.frame_err); end
    checks++; if (bus.ip_rx_en !== 1'b0) begin errors++; $display("FAIL rst_ipen got %0b exp 0", bus.ip_rx_en); end
    checks++; if (bus.frames_ok !== 16'd0) begin errors++; $display("FAIL rst_ok got %0d exp 0", bus.frames_ok); end
    checks++; if (bus.frames_drop !== 16'd0) begin errors++; $display("FAIL rst_drop got %0d exp 0", bus.frames_drop); end
  endtask

  task automatic test_good_frame();
    do_reset(); snap();
    build(16'h0800, 16'h1234, 16'h000C, 46);
    drive(46, 1'b1, 1'b1); settle();
    checks++; if (ip_cnt - b_ip !== 1) begin errors++; $display("FAIL good_ipen_cnt got %0d exp 1", ip_cnt - b_ip); end
    checks++; if (ip_idx !== 14) begin errors++; $display("FAIL good_ipen_idx got %0d exp 14", ip_idx); end
    checks++; if (tv_cnt - b_tv !== 4) begin errors++; $display("FAIL good_tv_cnt got %0d exp 4", tv_cnt - b_tv); end
    checks++; if (tv_start !== 42) begin errors++; $display("FAIL good_tv_start got %0d exp 42", tv_start); end
    checks++; if (tv_last !== 45) begin errors++; $display("FAIL good_tv_last got %0d exp 45", tv_last); end
    checks++; if (tl_cnt - b_tl !== 1) begin errors++; $display("FAIL good_tl_cnt got %0d exp 1", tl_cnt - b_tl); end
    checks++; if (tl_idx !== 45) begin errors++; $display("FAIL good_tl_idx got %0d exp 45", tl_idx); end
    checks++; if (last_tdata !== (8'hA0 ^ 8'd45)) begin errors++; $display("FAIL good_tdata got %0h exp %0h", last_tdata, 8'hA0 ^ 8'd45); end
    checks++; if (bus.frames_ok !== 16'd1) begin errors++; $display("FAIL good_ok got %0d exp 1", bus.frames_ok); end
    checks++; if (bus.frames_drop !== 16'd0) begin errors++; $display("FAIL good_drop got %0d exp 0", bus.frames_drop); end
  endtask

  task automatic test_filter();
    do_reset(); snap();
    build(16'h0806, 16'h1234, 16'h000C, 46);
    drive(46, 1'b1, 1'b1); settle();
    checks++; if (ip_cnt - b_ip !== 0) begin errors++; $display("FAIL etype_ipen got %0d exp 0", ip_cnt - b_ip); end
    checks++; if (tv_cnt - b_tv !== 0) begin errors++; $display("FAIL etype_tv got %0d exp 0", tv_cnt - b_tv); end
    checks++; if (bus.frames_drop !== 16'd1) begin errors++; $display("FAIL etype_drop got %0d exp 1", bus.frames_drop); end
    snap();
    build(16'h0800, 16'h1235, 16'h000C, 46);
    drive(46, 1'b1, 1'b1); settle();
    checks++; if (tv_cnt - b_tv !== 0) begin errors++; $display("FAIL port_tv got %0d exp 0", tv_cnt - b_tv); end
    checks++; if (bus.frames_drop !== 16'd2) begin errors++; $display("FAIL port_drop got %0d exp 2", bus.frames_drop); end
    checks++; if (bus.frames_ok !== 16'd0) begin errors++; $display("FAIL port_ok got %0d exp 0", bus.frames_ok); end
  endtask

  task automatic test_header_checks();
    do_reset(); snap();
    build(16'h0800, 16'h1234, 16'h000C, 46);
    drive(46, 1'b0, 1'b1); settle();
    checks++; if (tv_cnt - b_tv !== 0) begin errors++; $display("FAIL nodone_tv got %0d exp 0", tv_cnt - b_tv); end
    checks++; if (bus.frames_drop !== 16'd1) begin errors++; $display("FAIL nodone_drop got %0d exp 1", bus.frames_drop); end
    snap();
    build(16'h0800, 16'h1234, 16'h0008, 46);
    drive(46, 1'b1, 1'b1); settle();
    checks++; if (tv_cnt - b_tv !== 0) begin errors++; $display("FAIL len8_tv got %0d exp 0", tv_cnt - b_tv); end
    checks++; if (bus.frames_ok !== 16'd1) begin errors++; $display("FAIL len8_ok got %0d exp 1", bus.frames_ok); end
    build(16'h0800, 16'h1234, 16'h0005, 46);
    drive(46, 1'b1, 1'b1); settle();
    checks++; if (bus.frames_drop !== 16'd2) begin errors++; $display("FAIL len5_drop got %0d exp 2", bus.frames_drop); end
    checks++; if (bus.frames_ok !== 16'd1) begin errors++; $display("FAIL len5_ok got %0d exp 1", bus.frames_ok); end
  endtask

  task automatic test_truncation();
    do_reset(); snap();
    build(16'h0800, 16'h1234, 16'h0064, 52);
    drive(52, 1'b1, 1'b1); settle();
    checks++; if (tv_cnt - b_tv !== 10) begin errors++; $display("FAIL trunc_tv got %0d exp 10", tv_cnt - b_tv); end
    checks++; if (tl_cnt - b_tl !== 0) begin errors++; $display("FAIL trunc_tl got %0d exp 0", tl_cnt - b_tl); end
    checks++; if (fe_cnt - b_fe !== 1) begin errors++; $display("FAIL trunc_ferr_cycles got %0d exp 1", fe_cnt - b_fe); end
    checks++; if (bus.frames_drop !== 16'd1) begin errors++; $display("FAIL trunc_drop got %0d exp 1", bus.frames_drop); end
    checks++; if (bus.frames_ok !== 16'd0) begin errors++; $display("FAIL trunc_ok got %0d exp 0", bus.frames_ok); end
  endtask

  task automatic test_back_to_back();
    do_reset(); snap();
    build(16'h0800, 16'h1234, 16'h0009, 60);
    drive(60, 1'b1, 1'b1);
    build(16'h0800, 16'h1234, 16'h000C, 46);
    drive(46, 1'b1, 1'b1); settle();
    checks++; if (tv_cnt - b_tv !== 5) begin errors++; $display("FAIL b2b_tv got %0d exp 5", tv_cnt - b_tv); end
    checks++; if (tl_cnt - b_tl !== 2) begin errors++; $display("FAIL b2b_tl got %0d exp 2", tl_cnt - b_tl); end
    checks++; if (tv_start !== 42) begin errors++; $display("FAIL b2b_tv_start got %0d exp 42", tv_start); end
    checks++; if (tl_idx !== 45) begin errors++; $display("FAIL b2b_tl_idx got %0d exp 45", tl_idx); end
    checks++; if (bus.frames_ok !== 16'd2) begin errors++; $display("FAIL b2b_ok got %0d exp 2", bus.frames_ok); end
    checks++; if (bus.frames_drop !== 16'd0) begin errors++; $display("FAIL b2b_drop got %0d exp 0", bus.frames_drop); end
  endtask

  task automatic test_reset_mid_payload();
    do_reset();
    build(16'h0800, 16'h1234, 16'h000C, 46);
    drive(46, 1'b1, 1'b1); settle();
    build(16'h0800, 16'h1234, 16'h0064, 52);
    drive(45, 1'b1, 1'b0);
    @(negedge aclk);
    checks++; if (bus.m_tvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_tvalid got %0b exp 1", bus.m_tvalid); end
    #1 areset = 1'b1;
    #1;
    checks++; if (bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid got %0b exp 0", bus.m_tvalid); end
    checks++; if (bus.m_tdata !== 8'h00) begin errors++; $display("FAIL mid_tdata got %0h exp 0", bus.m_tdata); end
    checks++; if (bus.frames_ok !== 16'd0) begin errors++; $display("FAIL mid_ok got %0d exp 0", bus.frames_ok); end
    bus.data_valid = 1'b0; bus.ip_header_done = 1'b0;
    @(posedge aclk); #1 areset = 1'b0;
    cur_idx = 0;
    settle(); snap();
    build(16'h0800, 16'h1234, 16'h000C, 46);
    drive(46, 1'b1, 1'b1); settle();
    checks++; if (tv_cnt - b_tv !== 4) begin errors++; $display("FAIL mid_next_tv got %0d exp 4", tv_cnt - b_tv); end
    checks++; if (bus.frames_ok !== 16'd1) begin errors++; $display("FAIL mid_next_ok got %0d exp 1", bus.frames_ok); end
    checks++; if (bus.frames_drop !== 16'd0) begin errors++; $display("FAIL mid_next_drop got %0d exp 0", bus.frames_drop); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_filter();
    test_header_checks();
    test_truncation();
    test_back_to_back();
    test_reset_mid_payload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
